// File: rtl/rx_deframer.sv
// ============================================================================
//  Module      : rx_deframer
//  Description : Serial frame deframer. Decodes the header, recovers the
//                descrambler seed, and emits the descrambled PSDU bit stream.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rx_deframer (
    input  logic        Clk,
    input  logic        reset,
    input  logic        data_in,
    input  logic        in_valid,
    input  logic [5:0]  n_pad,
    output logic        data_out,
    output logic        out_valid,
    output logic [3:0]  rate,
    output logic [11:0] length,
    output logic        hdr_valid,
    output logic        parity_err,
    output logic [6:0]  seed,
    output logic        done
);

    typedef enum logic [2:0] {
        S_HDR     = 3'd0,
        S_SERVICE = 3'd1,
        S_PSDU    = 3'd2,
        S_TAIL    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t      state;
    logic [22:0] hdr_hist;
    logic [14:0] bit_cnt;
    logic [6:0]  tail_len;

    // The 24-bit header register as it stands once the current bit is shifted in;
    // the oldest bit is never needed again, so only 23 bits are stored.
    logic [23:0] hdr_next;
    logic        hdr_unused;
    logic        fb;
    logic        descr;
    logic        consume;
    logic [14:0] psdu_last;
    logic [6:0]  tail_entry_len;

    assign hdr_next       = {hdr_hist, data_in};
    assign hdr_unused     = ^{hdr_next[19], hdr_next[5:0]};
    assign fb             = seed[6] ^ seed[3];
    assign descr          = data_in ^ fb;
    assign consume        = in_valid && (state != S_DONE);
    assign psdu_last      = {length, 3'b000} - 15'd1;
    assign tail_entry_len = 7'd6 + {1'b0, n_pad};

    always_ff @(posedge Clk) begin
        if (!reset) begin
            state      <= S_HDR;
            hdr_hist   <= '0;
            bit_cnt    <= '0;
            tail_len   <= '0;
            data_out   <= 1'b0;
            out_valid  <= 1'b0;
            rate       <= '0;
            length     <= '0;
            hdr_valid  <= 1'b0;
            parity_err <= 1'b0;
            seed       <= '0;
            done       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            data_out  <= 1'b0;
            if (consume) begin
                bit_cnt <= bit_cnt + 15'd1;
                case (state)
                    S_HDR: begin
                        hdr_hist <= hdr_next[22:0];
                        if (bit_cnt == 15'd35) begin
                            bit_cnt <= '0;
                            if (^hdr_next[23:6] == 1'b0) begin
                                rate      <= hdr_next[23:20];
                                length    <= hdr_next[18:7];
                                hdr_valid <= 1'b1;
                                state     <= S_SERVICE;
                            end else begin
                                parity_err <= 1'b1;
                                done       <= 1'b1;
                                state      <= S_DONE;
                            end
                        end
                    end
                    S_SERVICE: begin
                        // Leading service bits are zero before scrambling, so they carry the seed directly.
                        if (bit_cnt < 15'd7)
                            seed <= {seed[5:0], data_in};
                        else
                            seed <= {seed[5:0], fb};
                        if (bit_cnt == 15'd15) begin
                            bit_cnt <= '0;
                            if (length == 12'd0) begin
                                tail_len <= tail_entry_len;
                                state    <= S_TAIL;
                            end else begin
                                state <= S_PSDU;
                            end
                        end
                    end
                    S_PSDU: begin
                        seed      <= {seed[5:0], fb};
                        data_out  <= descr;
                        out_valid <= 1'b1;
                        if (bit_cnt == psdu_last) begin
                            bit_cnt  <= '0;
                            tail_len <= tail_entry_len;
                            state    <= S_TAIL;
                        end
                    end
                    S_TAIL: begin
                        seed <= {seed[5:0], fb};
                        if (bit_cnt == {8'd0, tail_len} - 15'd1) begin
                            bit_cnt <= '0;
                            done    <= 1'b1;
                            state   <= S_DONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rx_deframer.sv
// ============================================================================
//  Module      : tb_rx_deframer
//  Description : Scoreboard bench for rx_deframer with directed frames.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rx_deframer;

    logic        Clk;
    logic        reset;
    logic        data_in;
    logic        in_valid;
    logic [5:0]  n_pad;
    logic        data_out;
    logic        out_valid;
    logic [3:0]  rate;
    logic [11:0] length;
    logic        hdr_valid;
    logic        parity_err;
    logic [6:0]  seed;
    logic        done;

    rx_deframer dut (
        .Clk        (Clk),
        .reset      (reset),
        .data_in    (data_in),
        .in_valid   (in_valid),
        .n_pad      (n_pad),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .rate       (rate),
        .length     (length),
        .hdr_valid  (hdr_valid),
        .parity_err (parity_err),
        .seed       (seed),
        .done       (done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int          checks = 0;
    int          passed = 0;
    int          cyc = 0;
    int          pulse_cnt = 0;
    logic [15:0] rx_word = '0;
    logic        exp_bit_q[$];
    int          exp_cyc_q[$];
    logic [6:0]  tx_st;
    logic        use_gaps = 1'b0;

    localparam logic [6:0]  TX_SEED  = 7'b1011011;
    localparam logic [11:0] PREFIX   = 12'h5A3;
    localparam logic [23:0] HDR_GOOD = 24'hD00100;
    localparam logic [23:0] HDR_BAD  = 24'hD00140;
    localparam logic [23:0] HDR_ZERO = 24'hD00040;
    localparam logic [15:0] PAYLOAD  = 16'h3CA5;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        else
            passed++;
    endtask

    // Monitor: every output pulse must match the oldest expected PSDU bit and its cycle.
    always @(negedge Clk) begin
        if (out_valid === 1'b1) begin
            checks++;
            if (exp_bit_q.size() == 0) begin
                $display("FAIL sb_unexpected: out_valid with empty queue, data_out %0b at cycle %0d", data_out, cyc);
            end else begin
                logic eb;
                int   ec;
                eb = exp_bit_q.pop_front();
                ec = exp_cyc_q.pop_front();
                if (data_out !== eb || cyc != ec)
                    $display("FAIL sb_bit: got bit %0b at cycle %0d expected bit %0b at cycle %0d", data_out, cyc, eb, ec);
                else
                    passed++;
            end
            pulse_cnt = pulse_cnt + 1;
            rx_word   = {data_out, rx_word[15:1]};
        end else if (data_out !== 1'b0) begin
            checks++;
            $display("FAIL idle_data: data_out %0b expected 0 while out_valid low, cycle %0d", data_out, cyc);
        end
    end

    function automatic logic scr(input logic d);
        logic f;
        f     = tx_st[6] ^ tx_st[3];
        tx_st = {tx_st[5:0], f};
        return d ^ f;
    endfunction

    // Entered just after a falling edge; returns at the falling edge after the bit was taken.
    task automatic send_bit(input logic b, input logic push, input logic exp);
        if (use_gaps) begin
            for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) begin
                data_in  = 1'($urandom_range(0, 1));
                in_valid = 1'b0;
                @(negedge Clk);
            end
        end
        data_in  = b;
        in_valid = 1'b1;
        if (push) begin
            exp_bit_q.push_back(exp);
            exp_cyc_q.push_back(cyc + 1);
        end
        @(negedge Clk);
        in_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check(name, 32'({data_out, out_valid, rate, length, hdr_valid, parity_err, seed, done}), 32'd0);
    endtask

    task automatic do_reset;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge Clk);
        reset     = 1'b1;
        pulse_cnt = 0;
        rx_word   = '0;
        exp_bit_q.delete();
        exp_cyc_q.delete();
    endtask

    task automatic send_frame(input logic [23:0] hdr, input int len, input logic [5:0] np,
                              input logic [15:0] payload, input int abort_at);
        logic pb;
        n_pad = np;
        for (int i = 11; i >= 0; i--) send_bit(PREFIX[i], 1'b0, 1'b0);
        for (int i = 23; i >= 0; i--) begin
            if (i == 0) check("hdr_not_valid_early", 32'(hdr_valid), 32'd0);
            send_bit(hdr[i], 1'b0, 1'b0);
        end
        check("hdr_valid", 32'(hdr_valid), 32'd1);
        check("rate", 32'(rate), 32'hD);
        check("length", 32'(length), 32'(len));
        for (int i = 6; i >= 0; i--) send_bit(TX_SEED[i], 1'b0, 1'b0);
        check("seed_recovered", 32'(seed), 32'(TX_SEED));
        tx_st = TX_SEED;
        for (int i = 0; i < 9; i++) send_bit(scr(1'b0), 1'b0, 1'b0);
        for (int k = 0; k < len * 8; k++) begin
            if (k == abort_at) begin
                data_in  = 1'b1;
                in_valid = 1'b1;
                reset    = 1'b0;
                @(negedge Clk);
                in_valid = 1'b0;
                check_all_zero("abort_outputs_zero");
                check("abort_queue_drained", 32'(exp_bit_q.size()), 32'd0);
                reset = 1'b1;
                return;
            end
            pb = payload[k];
            send_bit(scr(pb), 1'b1, pb);
        end
        for (int j = 0; j < 6 + int'(np); j++) begin
            if (j == 5 + int'(np)) check("done_not_early", 32'(done), 32'd0);
            send_bit(scr(1'b0), 1'b0, 1'b0);
        end
        check("done_at_end", 32'(done), 32'd1);
        check("no_parity_err", 32'(parity_err), 32'd0);
        check("final_seed", 32'(seed), 32'(tx_st));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        data_in  = 1'b0;
        n_pad    = '0;
        @(negedge Clk);
        @(negedge Clk);
        check_all_zero("reset_outputs");
        do_reset;

        // Good frame, continuous input
        send_frame(HDR_GOOD, 2, 6'd0, PAYLOAD, -1);
        #1;
        check("good_pulses", 32'(pulse_cnt), 32'd16);
        check("good_payload", 32'(rx_word), 32'(PAYLOAD));
        check("good_queue_empty", 32'(exp_bit_q.size()), 32'd0);

        // Extra bits after done change nothing
        for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        #1;
        check("b2b_done", 32'(done), 32'd1);
        check("b2b_hdr", 32'({hdr_valid, rate, length}), 32'({1'b1, 4'hD, 12'd2}));
        check("b2b_seed", 32'(seed), 32'(tx_st));
        check("b2b_pulses", 32'(pulse_cnt), 32'd16);
        do_reset;

        // Bad parity
        for (int i = 11; i >= 0; i--) send_bit(PREFIX[i], 1'b0, 1'b0);
        for (int i = 23; i >= 0; i--) begin
            if (i == 0) check("bad_done_not_early", 32'(done), 32'd0);
            send_bit(HDR_BAD[i], 1'b0, 1'b0);
        end
        check("bad_parity_err", 32'(parity_err), 32'd1);
        check("bad_done", 32'(done), 32'd1);
        check("bad_hdr_valid", 32'(hdr_valid), 32'd0);
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0, 1'b0);
        #1;
        check("bad_pulses", 32'(pulse_cnt), 32'd0);
        do_reset;

        // Zero length with padding
        send_frame(HDR_ZERO, 0, 6'd5, 16'h0000, -1);
        #1;
        check("zero_pulses", 32'(pulse_cnt), 32'd0);
        do_reset;

        // Good frame with idle gaps
        use_gaps = 1'b1;
        send_frame(HDR_GOOD, 2, 6'd0, PAYLOAD, -1);
        use_gaps = 1'b0;
        #1;
        check("gap_pulses", 32'(pulse_cnt), 32'd16);
        check("gap_payload", 32'(rx_word), 32'(PAYLOAD));
        do_reset;

        // Reset during PSDU bit 5, then a fresh frame
        send_frame(HDR_GOOD, 2, 6'd0, PAYLOAD, 5);
        pulse_cnt = 0;
        rx_word   = '0;
        send_frame(HDR_GOOD, 2, 6'd0, PAYLOAD, -1);
        #1;
        check("after_abort_pulses", 32'(pulse_cnt), 32'd16);
        check("after_abort_payload", 32'(rx_word), 32'(PAYLOAD));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rx_deframer.md
RX_DEFRAMER -- requirements
Module: rx_deframer

Interface
REQ-001 SHALL have port: Clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-low reset; sampled on Clk rising edge.
REQ-003 SHALL have port: data_in  input  1  serial frame bit.
REQ-004 SHALL have port: in_valid  input  1  data_in accepted this cycle when high.
REQ-005 SHALL have port: n_pad  input  6  pad bit count after 6 tail bits; sampled on entry to TAIL.
REQ-006 SHALL have port: data_out  output  1  descrambled PSDU bit.
REQ-007 SHALL have port: out_valid  output  1  data_out valid this cycle.
REQ-008 SHALL have port: rate  output  4  SIGNAL rate field.
REQ-009 SHALL have port: length  output  12  SIGNAL length field, in bytes.
REQ-010 SHALL have port: hdr_valid  output  1  rate/length captured and parity good; level.
REQ-011 SHALL have port: parity_err  output  1  SIGNAL parity failure; sticky level.
REQ-012 SHALL have port: seed  output  7  recovered descrambler seed.
REQ-013 SHALL have port: done  output  1  frame fully consumed or aborted; sticky level.

Function
REQ-014 SHALL implement states HDR, SERVICE, PSDU, TAIL, DONE; a bit SHALL be consumed only in a cycle with in_valid=1 and state not DONE.
REQ-015 HDR: SHALL consume 36 bits unscrambled, shifting each into a 24-bit register with the newest bit at LSB; after bit 36 the register holds the last 24 bits.
REQ-016 Field map of the 24-bit register: [23:20] rate, [19] reserved, [18:7] length, [6] even parity over [23:7], [5:0] tail.
REQ-017 On the 36th bit, SHALL compute parity on the register value including that bit; if XOR of [23:6] is 0 -> rate, length loaded, hdr_valid=1, go to SERVICE; otherwise parity_err=1, done=1, go to DONE.
REQ-018 SERVICE: SHALL consume 16 bits; bits 0..6 SHALL be shifted into seed (newest at LSB, as the scrambled value equals the scrambler sequence because the first 7 service bits are zero).
REQ-019 Descrambler SHALL use x^7+x^4+1: fb = seed[6]^seed[3]; descrambled bit = data_in^fb; seed <= {seed[5:0], fb}; SHALL advance on every consumed bit from service bit 7 to the end of TAIL.
REQ-020 Service bits 7..15 SHALL be descrambled but not output.
REQ-021 After service bit 15: length=0 -> TAIL; else PSDU.
REQ-022 PSDU: SHALL consume exactly length*8 bits using a 15-bit counter; each consumed bit SHALL appear on data_out with out_valid=1 on the following cycle (latency 1); then go to TAIL.
REQ-023 TAIL: SHALL consume 6+n_pad bits, no output; then go to DONE with done=1.
REQ-024 DONE SHALL hold all outputs until reset; further data_in ignored.
REQ-025 in_valid=0 in any state SHALL freeze counters, seed, and state; out_valid=0 the next cycle.
REQ-026 out_valid SHALL be high only for PSDU bits; data_out=0 when out_valid=0.
REQ-027 Bit counters SHALL reset to 0 on every state transition; no wrap within a state.

Reset
REQ-028 reset=0 at a rising edge SHALL force state HDR, counters 0, data_out 0, out_valid 0, rate 0, length 0, hdr_valid 0, parity_err 0, seed 0, done 0; the same SHALL hold when asserted mid-frame in any state.
REQ-029 reset=0 SHALL take priority over in_valid in the same cycle.

Verification
REQ-030 Good frame: rate 4'b1101, length 2, tx seed 7'b1011011, PSDU 8'hA5, 8'h3C, n_pad 0, in_valid=1 throughout -> hdr_valid=1, seed 7'b1011011 after service bit 6, 16 out_valid pulses reproducing A5, 3C in transmit order, done=1 exactly 36+16+16+6 valid bits after start.
REQ-031 Bad parity: same header with bit [6] flipped -> parity_err=1, done=1 after bit 36, hdr_valid=0, no out_valid.
REQ-032 Zero length: length 0, n_pad 5 -> no out_valid, done=1 after 36+16+11 bits.
REQ-033 Gaps: REQ-030 frame with in_valid toggled pseudo-randomly -> identical data_out sequence, out_valid only one cycle after each consumed PSDU bit.
REQ-034 Mid-frame reset: reset=0 at PSDU bit 5 -> all outputs 0 next cycle; a fresh REQ-030 frame then decodes correctly.
REQ-035 Back-to-back: extra bits after done=1 -> no output change until reset.
